// File: rtl/button_bank.sv
// N-channel button conditioner: synchroniser, debounce, edge ticks
// and hold-to-repeat key ticks, all in the clk_fast domain.
module button_bank #(
    parameter int              N_CH          = 5,
    parameter int              DB_CYCLES     = 800000,
    parameter int              REPEAT_DELAY  = 32000000,
    parameter int              REPEAT_PERIOD = 8000000,
    parameter logic [N_CH-1:0] REPEAT_MASK   = 5'b11110
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] press_tick,
    output logic [N_CH-1:0] release_tick,
    output logic [N_CH-1:0] key_tick,
    output logic            any_level
);

    localparam int CW   = $clog2(DB_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        RPT
    } rstate_t;

    assign any_level = |db_level;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [1:0]    sync;
        logic [CW-1:0] cnt;
        logic          db;
        logic          pt;
        logic          rt;
        logic          kt;
        logic          flip;
        logic          rise;
        logic          fall;
        logic          rep;
        rstate_t       state;
        rstate_t       state_nx;
        logic [RW-1:0] rcnt;
        logic [RW-1:0] rcnt_nx;

        assign flip = (sync[1] != db) && (cnt == CW'(DB_CYCLES - 1));
        assign rise = flip & ~db;
        assign fall = flip & db;

        assign db_level[i]     = db;
        assign press_tick[i]   = pt;
        assign release_tick[i] = rt;
        assign key_tick[i]     = kt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync  <= '0;
                cnt   <= '0;
                db    <= 1'b0;
                pt    <= 1'b0;
                rt    <= 1'b0;
                kt    <= 1'b0;
                state <= IDLE;
                rcnt  <= '0;
            end else begin
                sync <= {sync[0], btn_raw[i]};
                if (sync[1] == db) begin
                    cnt <= '0;
                end else if (flip) begin
                    cnt <= '0;
                    db  <= ~db;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                pt    <= rise;
                rt    <= fall;
                kt    <= rise | rep;
                state <= state_nx;
                rcnt  <= rcnt_nx;
            end
        end

        // A release wins over a coincident repeat so no pulse trails it
        always_comb begin
            state_nx = state;
            rcnt_nx  = rcnt;
            rep      = 1'b0;
            if (!REPEAT_MASK[i] || fall) begin
                state_nx = IDLE;
                rcnt_nx  = '0;
            end else if (rise) begin
                state_nx = DELAY;
                rcnt_nx  = '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        rcnt_nx = '0;
                    end
                    DELAY: begin
                        if (rcnt == RW'(REPEAT_DELAY - 1)) begin
                            rep      = 1'b1;
                            state_nx = RPT;
                            rcnt_nx  = '0;
                        end else begin
                            rcnt_nx = rcnt + 1'b1;
                        end
                    end
                    RPT: begin
                        if (rcnt == RW'(REPEAT_PERIOD - 1)) begin
                            rep     = 1'b1;
                            rcnt_nx = '0;
                        end else begin
                            rcnt_nx = rcnt + 1'b1;
                        end
                    end
                    default: begin
                        state_nx = IDLE;
                        rcnt_nx  = '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank: a history-based reference model
// queues the expected outputs per cycle; a negedge monitor compares.
module tb_button_bank;

    localparam int              N    = 5;
    localparam int              DB   = 4;
    localparam int              RD   = 20;
    localparam int              RP   = 5;
    localparam logic [N-1:0]    MASK = 5'b11110;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] db_level;
    logic [N-1:0] press_tick;
    logic [N-1:0] release_tick;
    logic [N-1:0] key_tick;
    logic         any_level;

    button_bank #(
        .N_CH         (N),
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .REPEAT_MASK  (MASK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .db_level    (db_level),
        .press_tick  (press_tick),
        .release_tick(release_tick),
        .key_tick    (key_tick),
        .any_level   (any_level)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [20:0] outs();
        return {db_level, press_tick, release_tick, key_tick, any_level};
    endfunction

    // Reference model: db flips once the last DB synchronised samples
    // all disagree with it; repeats are timed from the press cycle.
    logic [20:0]   q[$];
    int            cyc = 0;
    logic [N-1:0]  s1m, s2m, mdb;
    logic [DB-1:0] hist[N];
    int            pc[N];
    bit            held[N];

    initial begin
        logic [20:0]  e;
        logic [N-1:0] pt, rt, kt;
        int           d;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                s1m = '0;
                s2m = '0;
                mdb = '0;
                for (int i = 0; i < N; i++) begin
                    hist[i] = '0;
                    held[i] = 1'b0;
                    pc[i]   = 0;
                end
                e = '0;
            end else begin
                pt = '0;
                rt = '0;
                kt = '0;
                for (int i = 0; i < N; i++) begin
                    hist[i] = {hist[i][DB-2:0], s2m[i]};
                    if (hist[i] == {DB{~mdb[i]}}) begin
                        if (!mdb[i]) begin
                            pt[i]   = 1'b1;
                            kt[i]   = 1'b1;
                            pc[i]   = cyc;
                            held[i] = 1'b1;
                        end else begin
                            rt[i]   = 1'b1;
                            held[i] = 1'b0;
                        end
                        mdb[i] = ~mdb[i];
                    end else if (MASK[i] && held[i]) begin
                        d = cyc - pc[i];
                        if (d >= RD && (d - RD) % RP == 0)
                            kt[i] = 1'b1;
                    end
                end
                s2m = s1m;
                s1m = btn_raw;
                e = {mdb, pt, rt, kt, |mdb};
            end
            q.push_back(e);
        end
    end

    int kcnt[N];
    int pcnt[N];
    int rcnt[N];

    initial begin
        for (int i = 0; i < N; i++) begin
            kcnt[i] = 0;
            pcnt[i] = 0;
            rcnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (q.size() != 0) begin
            chk("cycle", 32'(outs()), 32'(q.pop_front()));
            for (int i = 0; i < N; i++) begin
                kcnt[i] += int'(key_tick[i]);
                pcnt[i] += int'(press_tick[i]);
                rcnt[i] += int'(release_tick[i]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_press(input int ch);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (press_tick[ch]) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("press_wait%0d", ch), 32'(ok), 32'd1);
    endtask

    int k0, p0, r0, k1;

    initial begin
        rst_n   = 1'b0;
        btn_raw = '1;
        step(3);
        chk("rst_out", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        step(5);
        chk("db_edge5", 32'(db_level), 32'd0);
        step(1);
        chk("db_edge6", 32'(db_level), 32'h1f);
        chk("press_all", 32'(press_tick), 32'h1f);
        chk("any_hi", 32'(any_level), 32'd1);
        step(1);
        chk("press_one", 32'(press_tick), 32'd0);
        btn_raw = '0;
        step(12);
        chk("any_lo", 32'(any_level), 32'd0);

        // glitch then a long-enough pulse on ch1
        p0 = pcnt[1];
        k0 = kcnt[1];
        r0 = rcnt[1];
        btn_raw[1] = 1'b1;
        step(3);
        btn_raw[1] = 1'b0;
        step(10);
        chk("glitch_press", 32'(pcnt[1] - p0), 32'd0);
        chk("glitch_key", 32'(kcnt[1] - k0), 32'd0);
        btn_raw[1] = 1'b1;
        step(6);
        btn_raw[1] = 1'b0;
        step(12);
        chk("pulse_press", 32'(pcnt[1] - p0), 32'd1);
        chk("pulse_rel", 32'(rcnt[1] - r0), 32'd1);

        // auto-repeat on ch2: press + 8 repeats before release
        k0 = kcnt[2];
        r0 = rcnt[2];
        btn_raw[2] = 1'b1;
        wait_press(2);
        step(52);
        btn_raw[2] = 1'b0;
        step(30);
        chk("ch2_keys", 32'(kcnt[2] - k0), 32'd9);
        chk("ch2_rel", 32'(rcnt[2] - r0), 32'd1);

        // masked ch0: one key tick only
        k0 = kcnt[0];
        btn_raw[0] = 1'b1;
        wait_press(0);
        step(60);
        chk("ch0_held", 32'(db_level[0]), 32'd1);
        btn_raw[0] = 1'b0;
        step(10);
        chk("ch0_keys", 32'(kcnt[0] - k0), 32'd1);

        // release during DELAY on ch3
        k0 = kcnt[3];
        btn_raw[3] = 1'b1;
        wait_press(3);
        step(10);
        btn_raw[3] = 1'b0;
        step(25);
        chk("ch3_keys", 32'(kcnt[3] - k0), 32'd1);

        // reset in the middle of ch4 repeating
        r0 = rcnt[4];
        btn_raw[4] = 1'b1;
        wait_press(4);
        step(30);
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'(outs()), 32'd0);
        step(2);
        rst_n = 1'b1;
        wait_press(4);
        chk("ch4_norel", 32'(rcnt[4] - r0), 32'd0);
        k1 = kcnt[4];
        step(19);
        chk("ch4_quiet", 32'(kcnt[4] - k1), 32'd0);
        step(1);
        chk("ch4_first", 32'(key_tick[4]), 32'd1);
        btn_raw[4] = 1'b0;
        step(15);

        // concurrent ch1 and ch4, ch1 released early
        k0 = kcnt[1];
        k1 = kcnt[4];
        btn_raw[1] = 1'b1;
        btn_raw[4] = 1'b1;
        wait_press(4);
        chk("aligned", 32'(press_tick[1]), 32'd1);
        step(27);
        btn_raw[1] = 1'b0;
        step(25);
        chk("ch1_keys", 32'(kcnt[1] - k0), 32'd4);
        chk("ch4_keys", 32'(kcnt[4] - k1), 32'd8);
        btn_raw[4] = 1'b0;
        step(20);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
